tone_envelope_gen: RTL and testbench

Tone generator that feeds the DAC top-level amplitude input `ampl`. It combines three stages:
- a DDS phase accumulator,
- a selectable waveform (square, saw, triangle, mute),
- a gate-driven linear attack/sustain/release envelope.

It emits a 12-bit offset-binary sample at a fixed sample rate derived from `clk` by an integer divider.

---
 rtl/tone_envelope_gen.sv | 161 ++++++++++++++++
 tb/tb_tone_envelope_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_envelope_gen.sv
// Tone generator for the DAC amplitude input: DDS phase accumulator, selectable
// waveform, gate-driven linear attack/sustain/release envelope, and a scaled
// offset-binary output sample produced once per divided sample tick.
module tone_envelope_gen #(
  parameter int CLK_DIV = 2500,
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         wave_sel,
  input  logic               gate,
  input  logic [11:0]        level,
  input  logic [11:0]        attack_step,
  input  logic [11:0]        release_step,
  input  logic               phase_clr,
  output logic [11:0]        ampl,
  output logic               ampl_valid,
  output logic               sample_tick,
  output logic [1:0]         env_state,
  output logic [11:0]        env
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  logic [CNT_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase;
  env_state_t         state, state_nxt;
  logic [11:0]        env_nxt;
  logic [12:0]        attack_sum;
  logic [11:0]        p;
  logic [10:0]        tri_t;
  logic [11:0]        wave;
  logic               tick_q;
  logic [11:0]        wave_q;
  logic [11:0]        env_q;
  logic signed [24:0] prod;
  logic [11:0]        scaled;
  logic               unused_prod;

  assign sample_tick = (div_cnt == DIV_LAST);
  assign env_state   = state;
  assign p           = phase[PHASE_W-1 -: 12];

  // Sample-rate divider: counts 0..CLK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // in the design samples the pre-edge values of its neighbours.
    if (reset)            div_cnt <= '0;
    else if (sample_tick) div_cnt <= '0;
    else                  div_cnt <= div_cnt + CNT_W'(1);
  end

  // Phase accumulator: clear wins at any cycle, increment only on ticks.
  always_ff @(posedge clk) begin
    if (reset)            phase <= '0;
    else if (phase_clr)   phase <= '0;
    else if (sample_tick) phase <= phase + freq_word;
  end

  // Waveform lookup from the top 12 phase bits, signed two's complement.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    wave  = 12'h000;
    tri_t = p[11] ? ~p[10:0] : p[10:0];
    case (wave_sel)
      2'd0:    wave = p[11] ? 12'h801 : 12'h7FF;
      2'd1:    wave = p ^ 12'h800;
      2'd2:    wave = {tri_t, 1'b0} - 12'h800;
      default: wave = 12'h000;
    endcase
  end

  // Envelope next-state and next-value logic, applied only on tick cycles.
  always_comb begin
    state_nxt  = state;
    env_nxt    = env;
    attack_sum = {1'b0, env} + {1'b0, attack_step};
    case (state)
      IDLE: begin
        if (gate) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_nxt = RELEASE;
        end else if (attack_step == 12'd0 || attack_sum >= {1'b0, level}) begin
          env_nxt   = level;
          state_nxt = SUSTAIN;
        end else begin
          env_nxt = attack_sum[11:0];
        end
      end
      SUSTAIN: begin
        if (!gate) state_nxt = RELEASE;
        else       env_nxt   = level;
      end
      RELEASE: begin
        if (gate) begin
          state_nxt = ATTACK;
        end else if (release_step == 12'd0 || env <= release_step) begin
          env_nxt   = 12'd0;
          state_nxt = IDLE;
        end else begin
          env_nxt = env - release_step;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Envelope state register, advanced on sample ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      env   <= 12'd0;
    end else if (sample_tick) begin
      state <= state_nxt;
      env   <= env_nxt;
    end
  end

  // Capture the waveform and envelope as they stood on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
      wave_q <= 12'd0;
      env_q  <= 12'd0;
    end else begin
      tick_q <= sample_tick;
      if (sample_tick) begin
        wave_q <= wave;
        env_q  <= env;
      end
    end
  end

  assign prod        = 25'($signed(wave_q)) * 25'($signed({1'b0, env_q}));
  assign scaled      = prod[23:12];
  assign unused_prod = ^{prod[24], prod[11:0]};

  // Output register: offset-binary sample plus one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ampl       <= 12'h800;
      ampl_valid <= 1'b0;
    end else begin
      ampl_valid <= tick_q;
      if (tick_q) ampl <= scaled ^ 12'h800;
    end
  end

endmodule

// File: tb/tb_tone_envelope_gen.sv
// Testbench for tone_envelope_gen: a cycle model pushes expected samples to a
// queue on every tick; a checker pops them on each ampl_valid. Directed steps
// check the envelope sequences, waveform extremes, wrap and reset.
module tb_tone_envelope_gen;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] freq_word;
  logic [1:0]  wave_sel;
  logic        gate;
  logic [11:0] level;
  logic [11:0] attack_step;
  logic [11:0] release_step;
  logic        phase_clr;
  logic [11:0] ampl;
  logic        ampl_valid;
  logic        sample_tick;
  logic [1:0]  env_state;
  logic [11:0] env;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_cnt   = 0;
  bit [23:0]   m_phase = '0;
  int          m_env   = 0;
  int          m_state = 0;
  bit          m_vd1   = 1'b0;
  bit          m_vd2   = 1'b0;
  logic [11:0] exp_q[$];

  tone_envelope_gen #(.CLK_DIV(CLK_DIV), .PHASE_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .freq_word    (freq_word),
    .wave_sel     (wave_sel),
    .gate         (gate),
    .level        (level),
    .attack_step  (attack_step),
    .release_step (release_step),
    .phase_clr    (phase_clr),
    .ampl         (ampl),
    .ampl_valid   (ampl_valid),
    .sample_tick  (sample_tick),
    .env_state    (env_state),
    .env          (env)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_ampl(input bit [11:0] pv, input int e, input bit [1:0] ws);
    int w;
    int pr;
    case (ws)
      2'd0:    w = pv[11] ? -2047 : 2047;
      2'd1:    w = int'(pv) - 2048;
      2'd2:    w = pv[11] ? 2 * (4095 - int'(pv)) - 2048 : 2 * int'(pv) - 2048;
      default: w = 0;
    endcase
    pr = w * e;
    return 12'((pr >>> 12) + 2048);
  endfunction

  // Cycle model of divider, phase, envelope and output latency.
  always @(posedge clk) begin
    bit t;
    int ne;
    int ns;
    if (reset) begin
      m_cnt   <= 0;
      m_phase <= '0;
      m_env   <= 0;
      m_state <= 0;
      m_vd1   <= 1'b0;
      m_vd2   <= 1'b0;
      exp_q.delete();
    end else begin
      t  = (m_cnt == CLK_DIV - 1);
      ne = m_env;
      ns = m_state;
      if (t) begin
        exp_q.push_back(model_ampl(m_phase[23:12], m_env, wave_sel));
        case (m_state)
          0: if (gate) ns = 1;
          1: begin
            if (!gate) ns = 3;
            else if (attack_step == 0 || m_env + int'(attack_step) >= int'(level)) begin
              ne = int'(level); ns = 2;
            end else ne = m_env + int'(attack_step);
          end
          2: begin
            if (!gate) ns = 3;
            else ne = int'(level);
          end
          default: begin
            if (gate) ns = 1;
            else if (release_step == 0 || m_env <= int'(release_step)) begin
              ne = 0; ns = 0;
            end else ne = m_env - int'(release_step);
          end
        endcase
      end
      m_vd1   <= t;
      m_vd2   <= m_vd1;
      m_cnt   <= t ? 0 : m_cnt + 1;
      m_phase <= phase_clr ? 24'd0 : (t ? m_phase + freq_word : m_phase);
      m_env   <= ne;
      m_state <= ns;
    end
  end

  // Per-cycle comparison against the model and scoreboard pop on valid.
  always @(negedge clk) begin
    check("sample_tick", 32'(sample_tick), 32'(m_cnt == CLK_DIV - 1));
    check("ampl_valid", 32'(ampl_valid), 32'(m_vd2));
    check("env_model", 32'(env), 32'(m_env));
    check("state_model", 32'(env_state), 32'(m_state));
    if (ampl_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_queue_empty", 32'(exp_q.size()), 32'd1);
      else                   check("ampl_sb", 32'(ampl), 32'(exp_q.pop_front()));
    end
  end

  task automatic to_tick();
    bit found = 1'b0;
    for (int i = 0; i < CLK_DIV + 2 && !found; i++) begin
      @(negedge clk);
      if (m_cnt == CLK_DIV - 1) found = 1'b1;
    end
  endtask

  task automatic tick();
    to_tick();
    @(negedge clk);
  endtask

  task automatic expect_env(input string tag, input int st, input int e);
    check({tag, "_state"}, 32'(env_state), 32'(st));
    check({tag, "_env"}, 32'(env), 32'(e));
  endtask

  task automatic sample_after_tick(input string tag, input logic [11:0] e);
    to_tick();
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(ampl_valid), 32'd1);
    check(tag, 32'(ampl), 32'(e));
  endtask

  task automatic pulse_clr();
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
  endtask

  logic [11:0] samp [32];

  initial begin
    int cyc;
    int k;
    int n_hi;
    int n_lo;
    reset = 1'b1; freq_word = '0; wave_sel = 2'd3; gate = 1'b0;
    level = '0; attack_step = '0; release_step = '0; phase_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ampl", 32'(ampl), 32'h800);
    check("rst_valid", 32'(ampl_valid), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    expect_env("rst", 0, 0);

    reset = 1'b0;
    cyc = 1;
    while (sample_tick !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("first_tick_cycle", 32'(cyc), 32'(CLK_DIV));

    // Mute and zero envelope
    repeat (4) tick();
    check("mute_idle_ampl", 32'(ampl), 32'h800);
    wave_sel = 2'd0; freq_word = 24'h100000;
    repeat (4) tick();
    check("square_no_gate_ampl", 32'(ampl), 32'h800);
    wave_sel = 2'd3; level = 12'd4095; gate = 1'b1;
    tick(); expect_env("inst_attack", 1, 0);
    tick(); expect_env("inst_sustain", 2, 4095);
    repeat (3) tick();
    check("mute_full_env_ampl", 32'(ampl), 32'h800);

    // Square output at full envelope, phase started from zero
    wave_sel = 2'd0;
    pulse_clr();
    tick();
    for (int i = 0; i < 32; i++) begin
      k = 0;
      while (ampl_valid !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
      samp[i] = ampl;
      @(negedge clk);
    end
    n_hi = 0; n_lo = 0;
    for (int i = 0; i < 32; i++) begin
      if (samp[i] == 12'hFFE) n_hi++;
      else if (samp[i] == 12'h001) n_lo++;
    end
    check("square_hi_count", 32'(n_hi), 32'd16);
    check("square_lo_count", 32'(n_lo), 32'd16);
    check("square_s0", 32'(samp[0]), 32'hFFE);
    check("square_s7", 32'(samp[7]), 32'hFFE);
    check("square_s8", 32'(samp[8]), 32'h001);
    check("square_s15", 32'(samp[15]), 32'h001);
    check("square_s16", 32'(samp[16]), 32'hFFE);

    // Instant release back to idle
    gate = 1'b0; release_step = 12'd0;
    tick(); expect_env("irel_release", 3, 4095);
    tick(); expect_env("irel_idle", 0, 0);

    // Envelope ramp
    level = 12'd3000; attack_step = 12'd1024; release_step = 12'd1000; gate = 1'b1;
    tick(); expect_env("ramp_a0", 1, 0);
    tick(); expect_env("ramp_a1", 1, 1024);
    tick(); expect_env("ramp_a2", 1, 2048);
    tick(); expect_env("ramp_sus", 2, 3000);
    gate = 1'b0;
    tick(); expect_env("ramp_r0", 3, 3000);
    tick(); expect_env("ramp_r1", 3, 2000);
    tick(); expect_env("ramp_r2", 3, 1000);
    tick(); expect_env("ramp_idle", 0, 0);

    // Gate changes mid-transition
    gate = 1'b1;
    tick(); expect_env("mid_a0", 1, 0);
    tick(); expect_env("mid_a1", 1, 1024);
    tick(); expect_env("mid_a2", 1, 2048);
    gate = 1'b0;
    tick(); expect_env("mid_rel_hold", 3, 2048);
    tick(); expect_env("mid_rel_dec", 3, 1048);
    gate = 1'b1;
    tick(); expect_env("mid_att_hold", 1, 1048);
    tick(); expect_env("mid_att_inc", 1, 2072);

    // Saw extremes at full envelope
    level = 12'd4095; attack_step = 12'd0;
    tick(); expect_env("saw_sus", 2, 4095);
    wave_sel = 2'd1; freq_word = 24'hFFF000;
    pulse_clr();
    sample_after_tick("saw_p000", 12'h000);
    sample_after_tick("saw_pfff", 12'hFFE);

    // Triangle through the scoreboard
    wave_sel = 2'd2; freq_word = 24'h0A5000;
    repeat (6) tick();

    // Phase wrap
    wave_sel = 2'd0; freq_word = 24'hFFFFFF;
    pulse_clr();
    tick();
    tick();
    check("phase_wrap", 32'(dut.phase), 32'hFFFFFE);

    // Reset mid-release
    freq_word = 24'h100000; release_step = 12'd100; gate = 1'b0;
    tick(); expect_env("prerst_rel", 3, 4095);
    tick(); expect_env("prerst_dec", 3, 3995);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ampl", 32'(ampl), 32'h800);
    check("midrst_valid", 32'(ampl_valid), 32'd0);
    check("midrst_tick", 32'(sample_tick), 32'd0);
    expect_env("midrst", 0, 0);
    reset = 1'b0;
    repeat (3) tick();
    expect_env("postrst", 0, 0);
    check("postrst_ampl", 32'(ampl), 32'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
